resta_serial: RTL and testbench
===============================

RESTA_SERIAL -- requirements
Module: resta_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 1..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request one subtraction; sampled on clk.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking r/borrow valid.
REQ-009 SHALL have port r  output  WIDTH  result a-b.
REQ-010 SHALL have port borrow  output  1  final borrow-out; 1 when a<b unsigned.

Function
REQ-011 SHALL compute a-b bit-serially, LSB first, with one 1-bit full-subtractor stage per cycle (R = A^B^Bin, Bout = ~A&B | ~(A^B)&Bin).
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: busy=0, done=0; start=1 -> capture a, b, clear borrow flop and bit counter, go RUN.
REQ-014 RUN: busy=1; each cycle feed shift-register LSBs and borrow flop to the stage, shift R into result MSB, update borrow flop, increment counter.
REQ-015 RUN -> DONE after exactly WIDTH RUN cycles; counter SHALL NOT wrap before the transition.
REQ-016 DONE: busy=0, done=1 for exactly one cycle, r/borrow valid; next state IDLE, or RUN if start=1 (back-to-back, capturing new a, b).
REQ-017 Latency: done SHALL be high in the cycle WIDTH+1 clocks after the edge that accepts start.
REQ-018 start while busy=1 SHALL be ignored; a/b changes during RUN SHALL NOT affect the result.
REQ-019 r and borrow SHALL hold their last values until the next DONE; they SHALL NOT show partial results outside DONE.
REQ-020 Without saturation, r SHALL equal (a-b) mod 2^WIDTH.

Reset
REQ-021 rst_n=0 SHALL force, immediately and asynchronously, state IDLE, busy=0, done=0, r=0, borrow=0, counter=0, shift registers=0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after release SHALL run normally.

Configuration
REQ-023 Macro RESTA_SERIAL_SAT_EN defined: when the final borrow=1, r SHALL be 0 in DONE; borrow still reports 1.
REQ-024 Macro RESTA_SERIAL_SAT_EN undefined: r SHALL be the wrapped difference per REQ-020; no saturation logic SHALL be present.

Structure
REQ-025 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH SHALL live in shared package resta_pkg.
REQ-026 The 1-bit stage SHALL be the existing sub-module resta (ports A, B, Bin, R, Bout), instantiated once; the controller holds the FSM, counter, shift registers and borrow flop.

Verification (WIDTH=8)
REQ-027 a=200, b=55, start 1 cycle -> busy 8 cycles, done at cycle 9, r=145, borrow=0.
REQ-028 a=5, b=9 -> r=252 and borrow=1 without macro; r=0 and borrow=1 with RESTA_SERIAL_SAT_EN.
REQ-029 a=255, b=255 then start held high in DONE with a=0, b=1 -> first done r=0, borrow=0; second done r=255, borrow=1, no idle gap.
REQ-030 a=10, b=3; start pulsed again at RUN cycle 3 with a=0, b=0 -> single done, r=7; second start ignored.
REQ-031 rst_n low at RUN cycle 4 -> busy, done, r, borrow 0 at once; no done pulse; next start a=1, b=0 -> r=1.
REQ-032 WIDTH=1, all 4 a/b combinations -> r and borrow match the full-subtractor truth table with Bin=0; done 2 cycles after start.

Source files
------------

// File: rtl/resta_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings,
// default operand width and the bit-counter width helper.
package resta_pkg;

  localparam int RESTA_WIDTH_DEFAULT = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter must hold the value WIDTH so it never wraps before RUN ends.
  function automatic int resta_cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/resta.sv
// One-bit full subtractor stage: R = A - B - Bin, Bout = borrow out.
module resta (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic R,
  output logic Bout
);

  assign R    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/resta_serial.sv
// Bit-serial subtractor r = a - b, LSB first, one bit per clock through a
// single full-subtractor stage. Control: IDLE -> RUN (WIDTH cycles) -> DONE.
// Optional build macro RESTA_SERIAL_SAT_EN: clamp r to 0 when the final
// borrow is set (borrow still reports 1). Without it r is the wrapped
// difference and no clamp logic exists.
module resta_serial
  import resta_pkg::*;
#(
  parameter int WIDTH = RESTA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             borrow
);

  localparam int CW = resta_cnt_width(WIDTH);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
  logic [WIDTH-1:0] r_reg;
  logic             borrow_reg;
  logic             bin_reg;
  logic [CW-1:0]    cnt_reg;

  logic             stage_r, stage_bout;
  logic [WIDTH-1:0] res_shifted;
  logic [WIDTH-1:0] r_final;
  logic             last_bit;
  logic             accept;

  // The single shared stage, fed from the operand shift-register LSBs.
  resta u_stage (
    .A    (a_sh_reg[0]),
    .B    (b_sh_reg[0]),
    .Bin  (bin_reg),
    .R    (stage_r),
    .Bout (stage_bout)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));
  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign busy     = (state_reg == RUN);
  assign done     = (state_reg == DONE);
  assign r        = r_reg;
  assign borrow   = borrow_reg;

  // Result shift: the new difference bit enters at the MSB.
  always_comb begin
    res_shifted            = res_sh_reg >> 1;
    res_shifted[WIDTH-1]   = stage_r;
`ifdef RESTA_SERIAL_SAT_EN
    r_final = stage_bout ? '0 : res_shifted;
`else
    r_final = res_shifted;
`endif
  end

  // Next-state logic; DONE may chain straight into RUN on a new start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Datapath: capture on accept, shift one bit per RUN cycle, publish on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      bin_reg    <= 1'b0;
      cnt_reg    <= '0;
      r_reg      <= '0;
      borrow_reg <= 1'b0;
    end else if (accept) begin
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      res_sh_reg <= '0;
      bin_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      res_sh_reg <= res_shifted;
      bin_reg    <= stage_bout;
      cnt_reg    <= cnt_reg + 1'b1;
      if (last_bit) begin
        r_reg      <= r_final;
        borrow_reg <= stage_bout;
      end
    end
  end

endmodule

// File: tb/tb_resta_serial.sv
// Scoreboard bench for resta_serial: an 8-bit instance for the main
// vectors and a 1-bit instance for the full-subtractor truth table.
module tb_resta_serial;

  typedef struct {
    logic [7:0] r;
    logic       b;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start1;
  logic [7:0] a8, b8, r8;
  logic       a1, b1, r1;
  logic       busy8, done8, borrow8;
  logic       busy1, done1, borrow1;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  resta_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .r(r8), .borrow(borrow8)
  );

  resta_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .r(r1), .borrow(borrow1)
  );

  function automatic logic [7:0] sat(input logic [7:0] rv, input logic bo);
`ifdef RESTA_SERIAL_SAT_EN
    return bo ? 8'd0 : rv;
`else
    return rv;
`endif
  endfunction

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (done8) begin
      exp_t e;
      n_tests++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL done8_unexpected cyc=%0d r=%0d borrow=%0d", cyc, r8, borrow8);
      end else begin
        e = q8.pop_front();
        if (r8 !== e.r || borrow8 !== e.b || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL done8 got r=%0d borrow=%0d cyc=%0d want r=%0d borrow=%0d cyc=%0d",
                   r8, borrow8, cyc, e.r, e.b, e.cyc);
        end else
          $display("[TB] w8 r=%0d borrow=%0d cyc=%0d ok", r8, borrow8, cyc);
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (done1) begin
      exp_t e;
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL done1_unexpected cyc=%0d r=%0d borrow=%0d", cyc, r1, borrow1);
      end else begin
        e = q1.pop_front();
        if ({7'd0, r1} !== e.r || borrow1 !== e.b || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL done1 got r=%0d borrow=%0d cyc=%0d want r=%0d borrow=%0d cyc=%0d",
                   r1, borrow1, cyc, e.r, e.b, e.cyc);
        end else
          $display("[TB] w1 r=%0d borrow=%0d cyc=%0d ok", r1, borrow1, cyc);
      end
    end
  end

  // Drive a start at the current negedge; done expected WIDTH+1 cycles later.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic eb, input bit push);
    a8 = av; b8 = bv; start8 = 1'b1;
    if (push) q8.push_back('{sat(er, eb), eb, cyc + 9});
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] er, input logic eb);
    issue8(av, bv, er, eb, 1'b1);
    @(negedge clk) start8 = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else
      $display("[TB] %s = %0h ok", name, got);
  endtask

  logic [7:0] va [4] = '{8'd0, 8'd0, 8'd128, 8'd100};
  logic [7:0] vb [4] = '{8'd0, 8'd1, 8'd127, 8'd200};
  logic [7:0] vr [4] = '{8'd0, 8'd255, 8'd1, 8'd156};
  logic       vo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int c, bc;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset8", {busy8, done8, r8, borrow8}, 32'd0);
    check("reset1", {busy1, done1, r1, borrow1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 200 - 55: busy for exactly 8 cycles, result held after the pulse.
    c = cyc;
    issue8(8'd200, 8'd55, 8'd145, 1'b0, 1'b1);
    @(negedge clk) start8 = 1'b0;
    bc = 0;
    for (int i = 0; i < 9; i++) begin
      if (busy8) bc++;
      if (i < 8) @(negedge clk);
    end
    check("busy_cycles", bc, 32'd8);
    @(negedge clk);
    check("hold_after_done", {done8, r8, borrow8}, {1'b0, 8'd145, 1'b0});

    run8(8'd5, 8'd9, 8'd252, 1'b1);
    for (int i = 0; i < 4; i++) run8(va[i], vb[i], vr[i], vo[i]);

    // Back-to-back: start held through RUN into DONE with new operands.
    c = cyc;
    issue8(8'd255, 8'd255, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    a8 = 8'd0; b8 = 8'd1;
    q8.push_back('{sat(8'd255, 1'b1), 1'b1, c + 18});
    repeat (8) @(negedge clk);
    @(negedge clk) start8 = 1'b0;
    repeat (9) @(negedge clk);

    // Start pulsed mid-RUN with new operands must be ignored.
    issue8(8'd10, 8'd3, 8'd7, 1'b0, 1'b1);
    @(negedge clk) start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'd0; b8 = 8'd0;
    @(negedge clk) start8 = 1'b0;
    repeat (16) @(negedge clk);

    // Asynchronous reset mid-RUN aborts with no done.
    issue8(8'd200, 8'd100, 8'd0, 1'b0, 1'b0);
    @(negedge clk) start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy8, done8, r8, borrow8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_after_abort", {busy8, done8}, 32'd0);
    run8(8'd1, 8'd0, 8'd1, 1'b0);

    // WIDTH=1 truth table with Bin=0; done 2 cycles after start.
    for (int i = 0; i < 4; i++) begin
      logic av, bv;
      av = i[1]; bv = i[0];
      a1 = av; b1 = bv; start1 = 1'b1;
      q1.push_back('{{7'd0, av ^ bv}, ~av & bv, cyc + 2});
      if (av == 1'b0 && bv == 1'b1) q1[$].r = sat(8'd1, 1'b1);
      @(negedge clk) start1 = 1'b0;
      repeat (2) @(negedge clk);
    end

    for (int i = 0; i < 40 && (q8.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    while (q8.size() != 0) begin
      exp_t e;
      e = q8.pop_front();
      n_tests++; n_fail++;
      $display("FAIL done8_timeout want r=%0d borrow=%0d cyc=%0d", e.r, e.b, e.cyc);
    end
    while (q1.size() != 0) begin
      exp_t e;
      e = q1.pop_front();
      n_tests++; n_fail++;
      $display("FAIL done1_timeout want r=%0d borrow=%0d cyc=%0d", e.r, e.b, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
